line_clear_sequencer: RTL
=========================

LINE_CLEAR_SEQUENCER -- requirements
Module: line_clear_sequencer

Interface
REQ-001 SHALL have parameter BOARD_ROWS, default 20: number of playfield rows, stored at VRAM words row_0_addr .. row_0_addr+BOARD_ROWS-1, with row 0 at the top.
REQ-002 SHALL have parameter BOARD_COLS, default 10: cells per row, 2 bits each, in word bits [2*BOARD_COLS-1:0].
REQ-003 CLK  input  1  single clock for all logic (50 MHz system clock).
REQ-004 RESET_N  input  1  reset, asynchronous assert, active-low.
REQ-005 START  input  1  single-cycle request to run one clear pass.
REQ-006 VBLANK  input  1  high when the port-B VRAM access is permitted.
REQ-007 RAM_ADDR  output  11  VRAM port-B address.
REQ-008 RAM_WDATA  output  32  VRAM port-B write data.
REQ-009 RAM_WREN  output  1  VRAM port-B write enable.
REQ-010 RAM_RDATA  input  32  VRAM port-B read data, valid 1 cycle after the address is presented.
REQ-011 BUSY  output  1  high from the START acceptance until DONE.
REQ-012 DONE  output  1  one-cycle pulse at the end of a pass.
REQ-013 CLEARED  output  5  number of full rows removed by the last pass, held until the next START.

Function
REQ-014 SHALL use states IDLE, RD_ISSUE, RD_WAIT, WR_ROW, FILL, LN_ISSUE, LN_WAIT, LN_ADD, LN_WR, FIN.
REQ-015 IDLE->RD_ISSUE on START=1; SHALL clear CLEARED and set rd=wr=BOARD_ROWS-1; START outside IDLE SHALL be ignored.
REQ-016 Every state that drives RAM_ADDR or RAM_WREN (RD_ISSUE, WR_ROW, FILL, LN_ISSUE, LN_WR) SHALL stall with RAM_WREN=0 while VBLANK=0, and SHALL proceed on the first cycle VBLANK=1.
REQ-017 RD_ISSUE: drive RAM_ADDR=row_0_addr+rd, then go to RD_WAIT.
REQ-018 RD_WAIT: capture RAM_RDATA regardless of VBLANK. A row is full when every 2-bit cell in [19:0] is nonzero.
REQ-019 On a full row, RD_WAIT SHALL increment CLEARED and leave wr unchanged.
REQ-020 On a non-full row with wr==rd, RD_WAIT SHALL decrement wr and skip the write.
REQ-021 On a non-full row with wr!=rd, RD_WAIT SHALL go to WR_ROW.
REQ-022 WR_ROW SHALL write the whole captured 32-bit word to row_0_addr+wr, then decrement wr.
REQ-023 After row rd=0 is processed, the FSM SHALL go to FILL if CLEARED>0, else to FIN. Otherwise it SHALL decrement rd and return to RD_ISSUE.
REQ-024 FILL SHALL write 32'h0 to row_0_addr+wr for each wr from its current value down to 0, one write per enabled cycle, then go to LN_ISSUE.
REQ-025 LN_ISSUE/LN_WAIT SHALL read level_lines_addr.
REQ-026 LN_ADD SHALL BCD-increment bits [15:0] once per cycle, CLEARED times. 9999 SHALL wrap to 0000, and bits [31:16] SHALL be unchanged.
REQ-027 LN_WR SHALL write the updated word back to level_lines_addr, then go to FIN.
REQ-028 FIN SHALL pulse DONE for 1 cycle, deassert BUSY and return to IDLE.
REQ-029 RAM_WREN SHALL be asserted only in WR_ROW, FILL and LN_WR.
REQ-030 RAM_ADDR SHALL never be outside row_0_addr..row_0_addr+BOARD_ROWS-1, except level_lines_addr.
REQ-031 The sequencer SHALL NOT read a row that it has already overwritten, because wr>=rd holds throughout.
REQ-032 All outputs SHALL be registered.

Reset
REQ-033 RESET_N=0 SHALL force IDLE asynchronously, with BUSY=0, DONE=0, RAM_WREN=0, RAM_ADDR=0, RAM_WDATA=0 and CLEARED=0.
REQ-034 Reset in the middle of a pass SHALL abandon it with no further writes; VRAM content already written is undefined and software owns recovery.

Structure
REQ-035 Package my_pkg SHALL hold row_0_addr, level_lines_addr, BOARD_ROWS_DEF, BOARD_COLS_DEF and the enum lc_state_t.
REQ-036 The 4-digit BCD incrementer SHALL be a sub-module bcd_inc4, purely combinational, with 16-bit input and 16-bit output.

Verification
REQ-037 Rows 18 and 19 = 0x000FFFFF, row 17 = 0x00000155, others 0; lines word 0x00010009; START with VBLANK=1 -> row 19 = 0x00000155, rows 0-18 = 0, CLEARED=2, lines word = 0x00010011, DONE once.
REQ-038 No full rows; START -> zero writes observed, CLEARED=0, lines word unchanged, DONE pulses.
REQ-039 Alternating rows full (rows 19,17,...,1 full, even rows = 0x1) -> rows 10-19 = 0x1, rows 0-9 = 0, CLEARED=10.
REQ-040 Same stimulus as REQ-037 with VBLANK toggling every 3 cycles -> identical final VRAM; RAM_WREN never high while VBLANK=0.
REQ-041 Lines = 0x9999 with one full row -> lines = 0x0000, bits [31:16] preserved; START pulsed while BUSY -> no second pass.
REQ-042 RESET_N low during FILL -> BUSY=0 and RAM_WREN=0 immediately, with no write after release; a new START then runs normally.

Source files
------------

// File: rtl/line_clear_sequencer_pkg.sv
// Shared constants, VRAM map and state encoding for the line-clear sequencer.
package my_pkg;

  localparam int unsigned ADDR_W         = 11;
  localparam int unsigned DATA_W         = 32;
  localparam int unsigned CNT_W          = 5;
  localparam int unsigned BOARD_ROWS_DEF = 20;
  localparam int unsigned BOARD_COLS_DEF = 10;

  // VRAM word map: playfield rows are contiguous, the lines counter sits apart.
  localparam logic [ADDR_W-1:0] row_0_addr       = 11'h100;
  localparam logic [ADDR_W-1:0] level_lines_addr = 11'h0F0;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    RD_ISSUE = 4'd1,
    RD_WAIT  = 4'd2,
    WR_ROW   = 4'd3,
    FILL     = 4'd4,
    LN_ISSUE = 4'd5,
    LN_WAIT  = 4'd6,
    LN_ADD   = 4'd7,
    LN_WR    = 4'd8,
    FIN      = 4'd9
  } lc_state_t;

endpackage

// File: rtl/line_clear_sequencer_if.sv
// VRAM port-B bus: the sequencer is master, the VRAM is slave.
interface line_clear_sequencer_if;
  import my_pkg::*;

  logic [ADDR_W-1:0] RAM_ADDR;
  logic [DATA_W-1:0] RAM_WDATA;
  logic              RAM_WREN;
  logic [DATA_W-1:0] RAM_RDATA;

  modport master (output RAM_ADDR, output RAM_WDATA, output RAM_WREN, input RAM_RDATA);
  modport slave  (input RAM_ADDR, input RAM_WDATA, input RAM_WREN, output RAM_RDATA);

endinterface

// File: rtl/line_clear_sequencer_bcd_inc4.sv
// Combinational +1 on a 4-digit packed BCD value; 9999 wraps to 0000.
module bcd_inc4 (
  input  logic [15:0] bcd_in,
  output logic [15:0] bcd_out
);

  logic       carry;
  logic [3:0] digit;

  // Ripple the +1 upward; a digit of 9 (or an invalid 10..15) rolls to 0 and carries.
  always_comb begin
    bcd_out = bcd_in;
    carry   = 1'b1;
    digit   = 4'd0;
    for (int i = 0; i < 4; i++) begin
      digit = bcd_in[4*i +: 4];
      if (carry) begin
        if (digit >= 4'd9) begin
          bcd_out[4*i +: 4] = 4'd0;
        end else begin
          bcd_out[4*i +: 4] = digit + 4'd1;
          carry             = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/line_clear_sequencer.sv
// Removes full playfield rows in VRAM during VBLANK, compacts the board downward
// and adds the number of removed rows to the BCD lines counter.
module line_clear_sequencer
  import my_pkg::*;
#(
  parameter int unsigned BOARD_ROWS = BOARD_ROWS_DEF,
  parameter int unsigned BOARD_COLS = BOARD_COLS_DEF
) (
  input  logic                      CLK,
  input  logic                      RESET_N,
  input  logic                      START,
  input  logic                      VBLANK,
  line_clear_sequencer_if.master    ram,
  output logic                      BUSY,
  output logic                      DONE,
  output logic [CNT_W-1:0]          CLEARED
);

  localparam int unsigned ROW_W = (BOARD_ROWS > 1) ? $clog2(BOARD_ROWS) : 1;
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(BOARD_ROWS - 1);

  localparam logic [3:0] S_IDLE     = 4'(IDLE);
  localparam logic [3:0] S_RD_ISSUE = 4'(RD_ISSUE);
  localparam logic [3:0] S_RD_WAIT  = 4'(RD_WAIT);
  localparam logic [3:0] S_WR_ROW   = 4'(WR_ROW);
  localparam logic [3:0] S_FILL     = 4'(FILL);
  localparam logic [3:0] S_LN_ISSUE = 4'(LN_ISSUE);
  localparam logic [3:0] S_LN_WAIT  = 4'(LN_WAIT);
  localparam logic [3:0] S_LN_ADD   = 4'(LN_ADD);
  localparam logic [3:0] S_LN_WR    = 4'(LN_WR);
  localparam logic [3:0] S_FIN      = 4'(FIN);

  logic [3:0]        state_q,   state_d;
  logic [ROW_W-1:0]  rd_q,      rd_d;
  logic [ROW_W-1:0]  wr_q,      wr_d;
  logic [CNT_W-1:0]  cleared_q, cleared_d;
  logic [CNT_W-1:0]  add_cnt_q, add_cnt_d;
  logic [DATA_W-1:0] data_q,    data_d;
  logic              phase_q,   phase_d;
  logic              busy_q,    busy_d;
  logic              done_q,    done_d;
  logic [ADDR_W-1:0] addr_q,    addr_d;
  logic [DATA_W-1:0] wdata_q,   wdata_d;
  logic              wren_q,    wren_d;

  logic              row_done;
  logic              last_row;
  logic              rd_full;
  logic [15:0]       bcd_next;

  function automatic logic row_full(input logic [DATA_W-1:0] w);
    logic full;
    full = 1'b1;
    for (int c = 0; c < int'(BOARD_COLS); c++) begin
      full = full & (|w[2*c +: 2]);
    end
    return full;
  endfunction

  function automatic logic [ADDR_W-1:0] row_addr(input logic [ROW_W-1:0] r);
    return row_0_addr + ADDR_W'(r);
  endfunction

  bcd_inc4 u_bcd_inc4 (
    .bcd_in  (data_q[15:0]),
    .bcd_out (bcd_next)
  );

  assign rd_full  = row_full(ram.RAM_RDATA);
  assign last_row = (rd_q == '0);

  // Next-state and next-output logic; every VRAM access waits for VBLANK.
  always_comb begin
    state_d   = state_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    cleared_d = cleared_q;
    add_cnt_d = add_cnt_q;
    data_d    = data_q;
    phase_d   = phase_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wren_d    = 1'b0;
    row_done  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (START) begin
          state_d   = S_RD_ISSUE;
          rd_d      = LAST_ROW;
          wr_d      = LAST_ROW;
          cleared_d = '0;
          busy_d    = 1'b1;
        end
      end
      S_RD_ISSUE: begin
        if (VBLANK) begin
          addr_d  = row_addr(rd_q);
          phase_d = 1'b0;
          state_d = S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        // First cycle presents the address, second cycle sees the read data.
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          data_d = ram.RAM_RDATA;
          if (rd_full) begin
            cleared_d = cleared_q + CNT_W'(1);
            row_done  = 1'b1;
          end else if (wr_q == rd_q) begin
            wr_d     = wr_q - ROW_W'(1);
            row_done = 1'b1;
          end else begin
            state_d = S_WR_ROW;
          end
        end
      end
      S_WR_ROW: begin
        if (VBLANK) begin
          addr_d   = row_addr(wr_q);
          wdata_d  = data_q;
          wren_d   = 1'b1;
          wr_d     = wr_q - ROW_W'(1);
          row_done = 1'b1;
        end
      end
      S_FILL: begin
        if (VBLANK) begin
          addr_d  = row_addr(wr_q);
          wdata_d = '0;
          wren_d  = 1'b1;
          if (wr_q == '0) begin
            state_d = S_LN_ISSUE;
          end else begin
            wr_d = wr_q - ROW_W'(1);
          end
        end
      end
      S_LN_ISSUE: begin
        if (VBLANK) begin
          addr_d  = level_lines_addr;
          phase_d = 1'b0;
          state_d = S_LN_WAIT;
        end
      end
      S_LN_WAIT: begin
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          data_d    = ram.RAM_RDATA;
          add_cnt_d = cleared_q;
          state_d   = S_LN_ADD;
        end
      end
      S_LN_ADD: begin
        if (add_cnt_q == '0) begin
          state_d = S_LN_WR;
        end else begin
          data_d[15:0] = bcd_next;
          add_cnt_d    = add_cnt_q - CNT_W'(1);
        end
      end
      S_LN_WR: begin
        if (VBLANK) begin
          addr_d  = level_lines_addr;
          wdata_d = data_q;
          wren_d  = 1'b1;
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase

    // A row has been consumed: step upward, or leave the scan after the top row.
    if (row_done) begin
      if (last_row) begin
        state_d = (cleared_d != '0) ? S_FILL : S_FIN;
      end else begin
        rd_d    = rd_q - ROW_W'(1);
        state_d = S_RD_ISSUE;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= S_IDLE;
      rd_q      <= '0;
      wr_q      <= '0;
      cleared_q <= '0;
      add_cnt_q <= '0;
      data_q    <= '0;
      phase_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wren_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      cleared_q <= cleared_d;
      add_cnt_q <= add_cnt_d;
      data_q    <= data_d;
      phase_q   <= phase_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wren_q    <= wren_d;
    end
  end

  assign ram.RAM_ADDR  = addr_q;
  assign ram.RAM_WDATA = wdata_q;
  assign ram.RAM_WREN  = wren_q;
  assign BUSY          = busy_q;
  assign DONE          = done_q;
  assign CLEARED       = cleared_q;

endmodule
